// File: rtl/lsu_dmem_ctrl.sv
// Load/store unit front end for a byte-lane data memory.
// Splits misaligned accesses into two word beats and extends load data.
module lsu_dmem_ctrl #(
    parameter int ADDR_W      = 12,
    parameter bit MISALIGN_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [3:0]        mem_wren,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [31:0]       mem_wrdata,
    input  logic [31:0]       mem_rddata
);

    localparam int AW = ADDR_W - 2;
    localparam logic [AW-1:0] ONE = 1;

    typedef enum logic [2:0] {
        IDLE, ST_B2, LD_W1, LD_W1S, LD_W2
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d, maddr_q;
    logic [1:0]    off_q, off_d, size_q, size_d;
    logic          uns_q, uns_d;
    logic [3:0]    wren2_q, wren2_d;
    logic [31:0]   wdata2_q, wdata2_d;
    logic [31:0]   lo_q, lo_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          rvalid_q, rvalid_d, rerr_q, rerr_d;

    logic [1:0]    o;
    logic [AW-1:0] a;
    logic [3:0]    nb, mask;
    logic [7:0]    lanes;
    logic [63:0]   sh;
    logic          mis, err, accept;
    logic [3:0]    wren_c;
    logic [AW-1:0] maddr_c;
    logic [31:0]   wrdata_c;

    function automatic logic [31:0] extract(
        input logic [63:0] w,
        input logic [1:0]  ofs,
        input logic [1:0]  sz,
        input logic        uns
    );
        logic [63:0] s;
        logic [31:0] r;
        s = w >> {ofs, 3'b000};
        r = s[31:0];
        unique case (sz)
            2'd0:    r = {{24{~uns & r[7]}}, r[7:0]};
            2'd1:    r = {{16{~uns & r[15]}}, r[15:0]};
            default: r = s[31:0];
        endcase
        return r;
    endfunction

    // Request decode: byte offset, lane mask, shifted data, fault checks
    always_comb begin
        o      = req_addr[1:0];
        a      = req_addr[ADDR_W-1:2];
        nb     = 4'd1 << req_size;
        unique case (req_size)
            2'd0:    mask = 4'b0001;
            2'd1:    mask = 4'b0011;
            default: mask = 4'b1111;
        endcase
        lanes  = {4'b0000, mask} << o;
        sh     = {32'd0, req_wdata} << {o, 3'b000};
        mis    = ({2'b00, o} + nb) > 4'd4;
        err    = (req_size == 2'd3)
               || ((req_addr >> ADDR_W) != 32'd0)
               || (mis && (!MISALIGN_EN || (&a)));
        accept = req_valid & req_ready;
    end

    // Next-state, memory beat and response generation
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        off_d    = off_q;
        size_d   = size_q;
        uns_d    = uns_q;
        wren2_d  = wren2_q;
        wdata2_d = wdata2_q;
        lo_d     = lo_q;
        rdata_d  = 32'd0;
        rvalid_d = 1'b0;
        rerr_d   = 1'b0;
        wren_c   = 4'b0000;
        maddr_c  = maddr_q;
        wrdata_c = 32'd0;
        unique case (state_q)
            IDLE: begin
                if (accept && err) begin
                    rvalid_d = 1'b1;
                    rerr_d   = 1'b1;
                end else if (accept) begin
                    addr_d   = a;
                    off_d    = o;
                    size_d   = req_size;
                    uns_d    = req_unsigned;
                    wren2_d  = lanes[7:4];
                    wdata2_d = sh[63:32];
                    maddr_c  = a;
                    if (req_we) begin
                        wren_c   = lanes[3:0];
                        wrdata_c = sh[31:0];
                        if (mis) state_d = ST_B2;
                        else     rvalid_d = 1'b1;
                    end else begin
                        state_d = mis ? LD_W1S : LD_W1;
                    end
                end
            end
            ST_B2: begin
                maddr_c  = addr_q + ONE;
                wren_c   = wren2_q;
                wrdata_c = wdata2_q;
                rvalid_d = 1'b1;
                state_d  = IDLE;
            end
            LD_W1: begin
                rdata_d  = extract({32'd0, mem_rddata}, off_q, size_q, uns_q);
                rvalid_d = 1'b1;
                state_d  = IDLE;
            end
            LD_W1S: begin
                maddr_c = addr_q + ONE;
                lo_d    = mem_rddata;
                state_d = LD_W2;
            end
            LD_W2: begin
                rdata_d  = extract({mem_rddata, lo_q}, off_q, size_q, uns_q);
                rvalid_d = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and data registers; reset aborts any beat in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            maddr_q  <= '0;
            off_q    <= '0;
            size_q   <= '0;
            uns_q    <= 1'b0;
            wren2_q  <= '0;
            wdata2_q <= '0;
            lo_q     <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            rerr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            maddr_q  <= maddr_c;
            off_q    <= off_d;
            size_q   <= size_d;
            uns_q    <= uns_d;
            wren2_q  <= wren2_d;
            wdata2_q <= wdata2_d;
            lo_q     <= lo_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            rerr_q   <= rerr_d;
        end
    end

    assign req_ready  = (state_q == IDLE) & ~rst;
    assign mem_wren   = wren_c & {4{~rst}};
    assign mem_addr   = maddr_c;
    assign mem_wrdata = wrdata_c;
    assign rsp_valid  = rvalid_q;
    assign rsp_rdata  = rdata_q;
    assign rsp_err    = rerr_q;

endmodule

// File: tb/tb_lsu_dmem_ctrl.sv
// Scoreboard bench for lsu_dmem_ctrl with a synchronous-read memory model.
// A second instance covers the misalignment-disabled configuration.
module tb_lsu_dmem_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        req_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata, mem_wrdata;
    logic [31:0] mem_rddata = '0;
    logic [3:0]  mem_wren;
    logic [9:0]  mem_addr;

    logic        b_valid = 1'b0, b_we = 1'b0;
    logic [1:0]  b_size = 2'd2;
    logic [31:0] b_addr = '0;
    logic        b_ready, b_rvalid, b_err;
    logic [31:0] b_rdata, b_wrdata;
    logic [3:0]  b_wren;
    logic [9:0]  b_maddr;

    logic        mem_clr = 1'b1;
    logic [31:0] mem [1024];

    typedef struct {
        int          cyc;
        logic [31:0] rdata;
        logic        err;
    } sb_t;
    sb_t sb [$];

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    lsu_dmem_ctrl #(.ADDR_W(12), .MISALIGN_EN(1'b1)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_wren(mem_wren), .mem_addr(mem_addr),
        .mem_wrdata(mem_wrdata), .mem_rddata(mem_rddata)
    );

    lsu_dmem_ctrl #(.ADDR_W(12), .MISALIGN_EN(1'b0)) dut_na (
        .clk(clk), .rst(rst),
        .req_valid(b_valid), .req_ready(b_ready),
        .req_we(b_we), .req_size(b_size),
        .req_unsigned(1'b0), .req_addr(b_addr),
        .req_wdata(32'h0BADF00D),
        .rsp_valid(b_rvalid), .rsp_rdata(b_rdata), .rsp_err(b_err),
        .mem_wren(b_wren), .mem_addr(b_maddr),
        .mem_wrdata(b_wrdata), .mem_rddata(32'd0)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 32'd0;
        end else begin
            for (int b = 0; b < 4; b++)
                if (mem_wren[b]) mem[mem_addr][8*b +: 8] <= mem_wrdata[8*b +: 8];
        end
        mem_rddata <= mem[mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rsp_valid) begin
            if (sb.size() == 0) begin
                chk("spurious_rsp", {31'd0, rsp_valid}, 32'd0);
            end else begin
                sb_t e;
                e = sb.pop_front();
                chk("rsp_cycle", cyc, e.cyc);
                chk("rsp_rdata", rsp_rdata, e.rdata);
                chk("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
            end
        end
    end

    task automatic drv(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] exp_rd, input logic exp_err,
                       input int lat, input bit push);
        sb_t e;
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wd;
        #1;
        chk("req_ready", {31'd0, req_ready}, 32'd1);
        if (push) begin
            e.cyc   = cyc + lat;
            e.rdata = exp_rd;
            e.err   = exp_err;
            sb.push_back(e);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 10) begin
            tick();
            n++;
        end
        chk("drain_left", sb.size(), 32'd0);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout got=%0d exp=0", sb.size());
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_wren", {28'd0, mem_wren}, 32'd0);
        chk("rst_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rdata", rsp_rdata, 32'd0);
        mem_clr = 1'b0;
        rst     = 1'b0;
        tick();

        drv(1, 2, 0, 32'h010, 32'h11223344, 32'd0, 0, 1, 1);
        chk("sw_wren", {28'd0, mem_wren}, 32'hF);
        chk("sw_addr", {22'd0, mem_addr}, 32'd4);
        chk("sw_wdata", mem_wrdata, 32'h11223344);
        tick();
        drv(0, 2, 0, 32'h010, 32'd0, 32'h11223344, 0, 2, 1);
        tick();
        chk("lw_busy", {31'd0, req_ready}, 32'd0);
        drain();

        drv(1, 0, 0, 32'h013, 32'h000000A5, 32'd0, 0, 1, 1);
        chk("sb_wren", {28'd0, mem_wren}, 32'h8);
        chk("sb_wdata", mem_wrdata, 32'hA5000000);
        tick();
        drv(0, 0, 0, 32'h013, 32'd0, 32'hFFFFFFA5, 0, 2, 1);
        drain();
        drv(0, 0, 1, 32'h013, 32'd0, 32'h000000A5, 0, 2, 1);
        drain();

        drv(1, 2, 0, 32'h022, 32'hDEADBEEF, 32'd0, 0, 2, 1);
        chk("mis_b1_addr", {22'd0, mem_addr}, 32'd8);
        chk("mis_b1_wren", {28'd0, mem_wren}, 32'hC);
        chk("mis_b1_wdata", mem_wrdata, 32'hBEEF0000);
        tick();
        chk("mis_b2_addr", {22'd0, mem_addr}, 32'd9);
        chk("mis_b2_wren", {28'd0, mem_wren}, 32'h3);
        chk("mis_b2_wdata", mem_wrdata, 32'h0000DEAD);
        chk("mis_b2_ready", {31'd0, req_ready}, 32'd0);
        drain();
        drv(0, 2, 0, 32'h022, 32'd0, 32'hDEADBEEF, 0, 3, 1);
        drain();
        drv(0, 1, 0, 32'h023, 32'd0, 32'hFFFFADBE, 0, 3, 1);
        drain();

        drv(0, 2, 0, 32'h1000, 32'd0, 32'd0, 1, 1, 1);
        chk("err_oob_wren", {28'd0, mem_wren}, 32'd0);
        tick();
        drv(1, 1, 0, 32'hFFF, 32'h1234, 32'd0, 1, 1, 1);
        chk("err_wrap_wren", {28'd0, mem_wren}, 32'd0);
        tick();
        drv(1, 3, 0, 32'h000, 32'h1234, 32'd0, 1, 1, 1);
        chk("err_sz3_wren", {28'd0, mem_wren}, 32'd0);
        drain();

        b_valid = 1'b1; b_we = 1'b0; b_size = 2'd2; b_addr = 32'h002;
        #1;
        chk("na_ready", {31'd0, b_ready}, 32'd1);
        chk("na_wren", {28'd0, b_wren}, 32'd0);
        @(negedge clk);
        b_we = 1'b1; b_addr = 32'h004;
        chk("na_mis_valid", {31'd0, b_rvalid}, 32'd1);
        chk("na_mis_err", {31'd0, b_err}, 32'd1);
        chk("na_mis_rdata", b_rdata, 32'd0);
        #1;
        chk("na_al_wren", {28'd0, b_wren}, 32'hF);
        @(negedge clk);
        b_valid = 1'b0;
        chk("na_al_valid", {31'd0, b_rvalid}, 32'd1);
        chk("na_al_err", {31'd0, b_err}, 32'd0);

        drv(1, 2, 0, 32'h002, 32'hCAFEF00D, 32'd0, 0, 2, 0);
        tick();
        rst = 1'b1;
        #1;
        chk("abort_wren", {28'd0, mem_wren}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort_ready", {31'd0, req_ready}, 32'd1);
        repeat (3) tick();
        chk("abort_word1", mem[1], 32'd0);
        chk("abort_word0", mem[0], 32'hF00D0000);

        for (int i = 0; i < 4; i++) begin
            drv(1, 2, 0, 32'h040 + 32'(4 * i), 32'h100 + 32'(i),
                32'd0, 0, 1, 1);
            chk("b2b_wren", {28'd0, mem_wren}, 32'hF);
            chk("b2b_addr", {22'd0, mem_addr}, 32'h10 + 32'(i));
            tick();
        end
        drv(0, 2, 0, 32'h04C, 32'd0, 32'h103, 0, 2, 1);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
